// File: rtl/uart_loopback_bist.sv
// Loopback BIST engine: streams a generated pattern into a uart and checks it on the way back.
// Optional LFSR pattern generator is enabled by defining UART_BIST_LFSR_EN.
module uart_loopback_bist #(
    parameter int               WIDTH     = 8,
    parameter int               CNT_W     = 16,
    parameter int               TMO_W     = 24,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [WIDTH-1:0] cfg_seed,
    input  logic             cfg_mode,
    input  logic [TMO_W-1:0] cfg_timeout,
    output logic             tx_req,
    output logic [WIDTH-1:0] tx_din,
    input  logic             tx_ready,
    output logic             rx_req,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_ready,
    input  logic             parity_err,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] rx_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] tx_sent_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [TMO_W-1:0] tmo_lim_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tick_q;
    logic [WIDTH-1:0] tx_gen_q;
    logic [WIDTH-1:0] rx_gen_q;
    logic [WIDTH-1:0] tx_din_q;
    logic             tx_req_q;
    logic             rx_req_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             timeout_q;

    logic [WIDTH-1:0] tx_gen_d;
    logic [WIDTH-1:0] rx_gen_d;
    logic [WIDTH-1:0] seed_d;
    logic             tmo_hit;
    logic             rx_bad;

`ifdef UART_BIST_LFSR_EN
    logic mode_q;

    function automatic logic [WIDTH-1:0] pat_next(
        input logic [WIDTH-1:0] w,
        input logic             m
    );
        pat_next = m ? ((w >> 1) ^ (w[0] ? LFSR_TAPS : '0)) : w + 1'b1;
    endfunction

    // An all-zero LFSR state would lock up, so seed 0 becomes 1.
    always_comb begin
        tx_gen_d = pat_next(tx_gen_q, mode_q);
        rx_gen_d = pat_next(rx_gen_q, mode_q);
        seed_d   = cfg_seed;
        if (cfg_mode && cfg_seed == '0)
            seed_d = {{(WIDTH-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst)
            mode_q <= 1'b0;
        else if (start && state_q != S_RUN)
            mode_q <= cfg_mode;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg_mode, LFSR_TAPS};

    always_comb begin
        tx_gen_d = tx_gen_q + 1'b1;
        rx_gen_d = rx_gen_q + 1'b1;
        seed_d   = cfg_seed;
    end
`endif

    assign tmo_hit = (tmo_lim_q != '0) && (tmo_cnt_q == tmo_lim_q);
    assign rx_bad  = (rx_data != rx_gen_q) || parity_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            tx_sent_q <= '0;
            rx_cnt_q  <= '0;
            err_cnt_q <= '0;
            tmo_lim_q <= '0;
            tmo_cnt_q <= '0;
            tick_q    <= 1'b0;
            tx_gen_q  <= '0;
            rx_gen_q  <= '0;
            tx_din_q  <= '0;
            tx_req_q  <= 1'b0;
            rx_req_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q   <= S_RUN;
                        count_q   <= cfg_count;
                        tmo_lim_q <= cfg_timeout;
                        tx_gen_q  <= seed_d;
                        rx_gen_q  <= seed_d;
                        tx_sent_q <= '0;
                        rx_cnt_q  <= '0;
                        err_cnt_q <= '0;
                        tmo_cnt_q <= '0;
                        tick_q    <= 1'b0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (rx_cnt_q == count_q || tmo_hit) begin
                        state_q   <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= (rx_cnt_q != count_q);
                        pass_q    <= (rx_cnt_q == count_q) && (err_cnt_q == '0);
                        tx_req_q  <= 1'b0;
                        rx_req_q  <= 1'b0;
                    end else begin
                        if (tx_req_q) begin
                            tx_req_q <= 1'b0;
                        end else if (tx_ready && tx_sent_q < count_q) begin
                            tx_req_q  <= 1'b1;
                            tx_din_q  <= tx_gen_q;
                            tx_gen_q  <= tx_gen_d;
                            tx_sent_q <= tx_sent_q + 1'b1;
                        end
                        // rx_req high means the uart pops this edge.
                        if (rx_req_q) begin
                            rx_req_q  <= 1'b0;
                            rx_cnt_q  <= rx_cnt_q + 1'b1;
                            rx_gen_q  <= rx_gen_d;
                            tmo_cnt_q <= '0;
                            tick_q    <= 1'b0;
                            if (rx_bad && err_cnt_q != '1)
                                err_cnt_q <= err_cnt_q + 1'b1;
                        end else begin
                            if (rx_ready && rx_cnt_q < count_q)
                                rx_req_q <= 1'b1;
                            tick_q <= ~tick_q;
                            if (tick_q)
                                tmo_cnt_q <= tmo_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_req  = tx_req_q;
    assign tx_din  = tx_din_q;
    assign rx_req  = rx_req_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign timeout = timeout_q;
    assign err_cnt = err_cnt_q;
    assign rx_cnt  = rx_cnt_q;

endmodule

// File: tb/tb_uart_loopback_bist.sv
// Bench for uart_loopback_bist: behavioural uart FIFO/serializer loopback plus a tx_din scoreboard.
// Build with UART_BIST_LFSR_EN defined to exercise the LFSR pattern.
module tb_uart_loopback_bist;

`ifdef UART_BIST_LFSR_EN
    localparam bit LFSR_ON = 1'b1;
`else
    localparam bit LFSR_ON = 1'b0;
`endif
    localparam int SER = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_count;
    logic [7:0]  cfg_seed;
    logic        cfg_mode;
    logic [23:0] cfg_timeout;
    logic        tx_req;
    logic [7:0]  tx_din;
    logic        tx_ready;
    logic        rx_req;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        parity_err;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] err_cnt;
    logic [15:0] rx_cnt;

    uart_loopback_bist dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_count  (cfg_count),
        .cfg_seed   (cfg_seed),
        .cfg_mode   (cfg_mode),
        .cfg_timeout(cfg_timeout),
        .tx_req     (tx_req),
        .tx_din     (tx_din),
        .tx_ready   (tx_ready),
        .rx_req     (rx_req),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .timeout    (timeout),
        .err_cnt    (err_cnt),
        .rx_cnt     (rx_cnt)
    );

    always #5 clk = ~clk;

    // uart model: 8-deep TX FIFO, fixed-time serializer, RX FIFO
    logic [7:0] txq[$];
    logic [8:0] rxq[$];
    logic [7:0] ser_word;
    logic       ser_busy;
    int         ser_cnt;
    int         ser_idx;
    int         flip_idx = -1;
    int         par_a = -1;
    int         par_b = -1;
    bit         line_dead = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            txq.delete();
            rxq.delete();
            ser_busy <= 1'b0;
            ser_cnt  <= 0;
            ser_idx  <= 0;
        end else begin
            if (tx_req)
                txq.push_back(tx_din);
            if (rx_req && rxq.size() > 0)
                rxq.delete(0);
            if (ser_busy) begin
                ser_cnt <= ser_cnt - 1;
                if (ser_cnt == 1) begin
                    ser_busy <= 1'b0;
                    if (!line_dead)
                        rxq.push_back({(ser_idx == par_a) || (ser_idx == par_b),
                                       ser_word ^ {7'd0, ser_idx == flip_idx}});
                end
            end else if (txq.size() > 0) begin
                ser_word <= txq[0];
                txq.delete(0);
                ser_busy <= 1'b1;
                ser_cnt  <= SER;
            end
            if (start && !busy)
                ser_idx <= 0;
            else if (ser_busy && ser_cnt == 1)
                ser_idx <= ser_idx + 1;
        end
        tx_ready   <= (txq.size() < 8);
        rx_ready   <= (rxq.size() > 0);
        rx_data    <= (rxq.size() > 0) ? rxq[0][7:0] : 8'h00;
        parity_err <= (rxq.size() > 0) ? rxq[0][8] : 1'b0;
    end

    int         tests = 0;
    int         fails = 0;
    logic [7:0] expq[$];
    int         pops = 0;
    int         tx_seen = 0;
    int         b2b = 0;
    bit         tx_prev = 1'b0;
    int         lat;
    int         base_pops;
    int         base_tx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] nxt(input logic [7:0] w, input bit m);
        if (m && LFSR_ON)
            return {1'b0, w[7:1]} ^ (w[0] ? 8'hB8 : 8'h00);
        return w + 8'd1;
    endfunction

    // One cycle: sample at negedge, scoreboard every push.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            if (tx_req) begin
                tx_seen++;
                if (tx_prev)
                    b2b++;
                if (expq.size() == 0) begin
                    chk("tx_extra", 1, 0);
                end else begin
                    chk("tx_din", {24'd0, tx_din}, {24'd0, expq[0]});
                    expq.delete(0);
                end
            end
            if (rx_req)
                pops++;
        end
        tx_prev = tx_req;
    endtask

    task automatic start_run(input int cnt, input logic [7:0] seed,
                             input bit m, input int tmo);
        logic [7:0] w;
        w = seed;
        if (m && LFSR_ON && seed == 8'h00)
            w = 8'h01;
        for (int i = 0; i < cnt; i++) begin
            expq.push_back(w);
            w = nxt(w, m);
        end
        base_pops   = pops;
        base_tx     = tx_seen;
        b2b         = 0;
        cfg_count   = 16'(cnt);
        cfg_seed    = seed;
        cfg_mode    = m;
        cfg_timeout = 24'(tmo);
        start       = 1'b1;
        tick();
        start       = 1'b0;
        lat         = 1;
    endtask

    task automatic wait_done(input int bound);
        while (!done && lat < bound) begin
            tick();
            lat++;
        end
        chk("done", {31'd0, done}, 1);
    endtask

    task automatic results(input bit p, input int rc, input int ec, input bit to);
        chk("pass", {31'd0, pass}, {31'd0, p});
        chk("rx_cnt", {16'd0, rx_cnt}, rc);
        chk("err_cnt", {16'd0, err_cnt}, ec);
        chk("timeout", {31'd0, timeout}, {31'd0, to});
        chk("busy_end", {31'd0, busy}, 0);
        chk("tx_left", expq.size(), 0);
        chk("pops", pops - base_pops, rc);
        chk("tx_b2b", b2b, 0);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        cfg_count   = '0;
        cfg_seed    = '0;
        cfg_mode    = 1'b0;
        cfg_timeout = '0;
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_pass", {31'd0, pass}, 0);
        chk("rst_treq", {31'd0, tx_req}, 0);
        chk("rst_rreq", {31'd0, rx_req}, 0);
        chk("rst_txdin", {24'd0, tx_din}, 0);
        chk("rst_cnts", {err_cnt, rx_cnt}, 0);
        rst = 1'b0;
        tick();

        // incrementing stream, generous timeout that must not fire
        start_run(20, 8'h00, 1'b0, 200);
        wait_done(3000);
        results(1'b1, 20, 0, 1'b0);

        // bit 0 flipped on the 6th word
        flip_idx = 5;
        start_run(20, 8'h00, 1'b0, 0);
        wait_done(3000);
        results(1'b0, 20, 1, 1'b0);

        // word 2 corrupt plus parity counts once, word 4 parity only
        flip_idx = 2;
        par_a    = 2;
        par_b    = 4;
        start_run(8, 8'h10, 1'b0, 0);
        wait_done(2000);
        results(1'b0, 8, 2, 1'b0);
        flip_idx = -1;
        par_a    = -1;
        par_b    = -1;

        // pattern wraps 0xFF -> 0x00
        start_run(20, 8'hF8, 1'b0, 0);
        wait_done(3000);
        results(1'b1, 20, 0, 1'b0);

        // empty run
        start_run(0, 8'h00, 1'b0, 0);
        wait_done(50);
        chk("cnt0_lat", lat, 2);
        chk("cnt0_tx", tx_seen - base_tx, 0);
        results(1'b1, 0, 0, 1'b0);

        // dead line: timeout after 5000 ticks of the half-rate counter
        line_dead = 1'b1;
        start_run(20, 8'h00, 1'b0, 5000);
        wait_done(12000);
        chk("tmo_lat", (lat >= 10001 && lat <= 10003) ? 1 : 0, 1);
        results(1'b0, 0, 0, 1'b1);
        line_dead = 1'b0;

        // reset after 3 pops, then a clean rerun
        start_run(20, 8'h00, 1'b0, 0);
        while (pops - base_pops < 3 && lat < 3000) begin
            tick();
            lat++;
        end
        chk("pre_rst_pops", (pops - base_pops >= 3) ? 1 : 0, 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_reqs", {30'd0, tx_req, rx_req}, 0);
        chk("mid_rst_cnt", {16'd0, rx_cnt}, 0);
        chk("mid_rst_din", {24'd0, tx_din}, 0);
        rst = 1'b0;
        expq.delete();
        tick();
        start_run(10, 8'h00, 1'b0, 0);
        wait_done(2000);
        results(1'b1, 10, 0, 1'b0);

        // mode 1 (LFSR when enabled); a start while busy is ignored
        start_run(16, 8'h01, 1'b1, 0);
        repeat (30) begin
            tick();
            lat++;
        end
        cfg_count = 16'd3;
        cfg_seed  = 8'h77;
        start     = 1'b1;
        tick();
        lat++;
        start     = 1'b0;
        chk("restart_busy", {31'd0, busy}, 1);
        wait_done(3000);
        results(1'b1, 16, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
